// File: rtl/impli_stim_gen_if.sv
// Control and observation bundle for the implication stimulus generator.
// The master side issues bursts and reads back the a/b drive and the counters.
interface impli_stim_gen_if;
   logic       start;
   logic [7:0] num_txn;
   logic [3:0] err_period;
   logic       a;
   logic       b;
   logic       busy;
   logic       done;
   logic [7:0] txn_cnt;
   logic [7:0] vac_cnt;
   logic [7:0] err_cnt;

   modport master (
      output start, num_txn, err_period,
      input  a, b, busy, done, txn_cnt, vac_cnt, err_cnt
   );

   modport slave (
      input  start, num_txn, err_period,
      output a, b, busy, done, txn_cnt, vac_cnt, err_cnt
   );
endinterface

// File: rtl/impli_stim_gen.sv
// Stimulus generator for the property "a ##1 b |-> ##1 a".
// Each transaction spans A/B/C phases plus an optional LFSR-chosen idle gap;
// it is full, vacuous (b stays low) or violating (a low in the C phase).
// Counters tell the checker exactly how many passes and failures to expect.
module impli_stim_gen #(
   parameter logic [15:0] SEED      = 16'hACE1,
   parameter bit          ALLOW_VAC = 1'b1,
   parameter int unsigned MAX_GAP   = 3
) (
   input logic             clk,
   input logic             rst_n,
   impli_stim_gen_if.slave bus
);

   localparam logic [15:0] LfsrMask = 16'hB400;
   localparam logic [1:0]  MaxGap   = (MAX_GAP > 3) ? 2'd3 : 2'(MAX_GAP);

   typedef enum logic [2:0] {StIdle, StAPh, StBPh, StCPh, StGap, StDone} state_t;

   state_t      state_q;
   logic [15:0] lfsr_q;
   logic [7:0]  num_lat_q;
   logic [3:0]  ep_lat_q;
   logic [3:0]  full_mod_q;
   logic        vac_q;
   logic        viol_q;
   logic [1:0]  gap_len_q;
   logic [1:0]  gap_rem_q;
   logic        a_q;
   logic        b_q;
   logic        busy_q;
   logic        done_q;
   logic [7:0]  txn_cnt_q;
   logic [7:0]  vac_cnt_q;
   logic [7:0]  err_cnt_q;

   logic [15:0] lfsr_next;
   logic [1:0]  gap_sel;
   logic        pick_vac;
   logic [3:0]  mod_inc;
   logic        hit_err;
   logic [7:0]  txn_inc;
   logic        burst_end;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? 8'hFF : v + 8'd1;
   endfunction

   // Next LFSR value, per-transaction choices and the end-of-burst test.
   always_comb begin
      lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrMask : 16'h0000);
      gap_sel   = (lfsr_q[2:1] > MaxGap) ? MaxGap : lfsr_q[2:1];
      pick_vac  = ALLOW_VAC && lfsr_q[0];
      mod_inc   = full_mod_q + 4'd1;
      hit_err   = !vac_q && (ep_lat_q != 4'd0) && (mod_inc == ep_lat_q);
      txn_inc   = sat_inc(txn_cnt_q);
      // Leaving C_PH the count has not been updated yet, so look ahead.
      burst_end = (state_q == StCPh) ? (txn_inc == num_lat_q) : (txn_cnt_q == num_lat_q);
   end

   // Sequencer with registered a/b/busy/done and counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         lfsr_q     <= SEED;
         num_lat_q  <= 8'd0;
         ep_lat_q   <= 4'd0;
         full_mod_q <= 4'd0;
         vac_q      <= 1'b0;
         viol_q     <= 1'b0;
         gap_len_q  <= 2'd0;
         gap_rem_q  <= 2'd0;
         a_q        <= 1'b0;
         b_q        <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         txn_cnt_q  <= 8'd0;
         vac_cnt_q  <= 8'd0;
         err_cnt_q  <= 8'd0;
      end else begin
         case (state_q)
            StIdle: begin
               if (bus.start) begin
                  num_lat_q  <= bus.num_txn;
                  ep_lat_q   <= bus.err_period;
                  full_mod_q <= 4'd0;
                  txn_cnt_q  <= 8'd0;
                  vac_cnt_q  <= 8'd0;
                  err_cnt_q  <= 8'd0;
                  if (bus.num_txn == 8'd0) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= StAPh;
                     a_q     <= 1'b1;
                     busy_q  <= 1'b1;
                  end
               end
            end
            StAPh: begin
               // Choices use the LFSR value held during this phase.
               vac_q     <= pick_vac;
               gap_len_q <= gap_sel;
               lfsr_q    <= lfsr_next;
               a_q       <= 1'b0;
               b_q       <= !pick_vac;
               state_q   <= StBPh;
            end
            StBPh: begin
               viol_q <= hit_err;
               if (!vac_q && (ep_lat_q != 4'd0)) begin
                  full_mod_q <= hit_err ? 4'd0 : mod_inc;
               end
               a_q     <= !vac_q && !hit_err;
               b_q     <= 1'b0;
               state_q <= StCPh;
            end
            StCPh: begin
               txn_cnt_q <= txn_inc;
               if (vac_q) vac_cnt_q <= sat_inc(vac_cnt_q);
               if (viol_q) err_cnt_q <= sat_inc(err_cnt_q);
               if (gap_len_q != 2'd0) begin
                  state_q   <= StGap;
                  a_q       <= 1'b0;
                  gap_rem_q <= gap_len_q;
               end else if (burst_end) begin
                  state_q <= StDone;
                  a_q     <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  // Back-to-back: a stays high into the next A phase.
                  state_q <= StAPh;
                  a_q     <= 1'b1;
               end
            end
            StGap: begin
               if (gap_rem_q != 2'd1) begin
                  gap_rem_q <= gap_rem_q - 2'd1;
               end else if (burst_end) begin
                  state_q <= StDone;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= StAPh;
                  a_q     <= 1'b1;
               end
            end
            StDone: begin
               done_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
               a_q     <= 1'b0;
               b_q     <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.a       = a_q;
   assign bus.b       = b_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.txn_cnt = txn_cnt_q;
   assign bus.vac_cnt = vac_cnt_q;
   assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_impli_stim_gen.sv
// Bench for impli_stim_gen: randomized bursts predicted by a transaction-level
// model; a monitor pops expectations on each counter step and on done, and an
// in-bench implication checker tallies passes, failures and vacuous attempts.
module tb_impli_stim_gen;
   localparam logic [15:0] SEED    = 16'hACE1;
   localparam int          MAX_GAP = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   impli_stim_gen_if bus ();
   impli_stim_gen_if bus2 ();

   impli_stim_gen #(.SEED(SEED), .ALLOW_VAC(1'b1), .MAX_GAP(MAX_GAP)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave)
   );

   impli_stim_gen #(.SEED(SEED), .ALLOW_VAC(1'b0), .MAX_GAP(0)) u_dut_full (
      .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
   );

   typedef struct { int txn; int vac; int err; } txn_exp_t;
   typedef struct { int txn; int vac; int err; int cycles; int pass; int fail; int vatt; } done_exp_t;

   txn_exp_t    txn_q[$];
   done_exp_t   done_q[$];
   logic [15:0] m_lfsr = SEED;
   int          n_cmp = 0;
   int          n_fail = 0;

   function automatic void check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
   endfunction

   // Predict a burst from the transaction rules and queue the expectations.
   task automatic plan_burst(input int n, input int ep);
      int        full = 0, tx = 0, vc = 0, er = 0, cyc = 0;
      logic [1:0] g;
      bit        vac, viol;
      txn_exp_t  t;
      done_exp_t d;
      for (int i = 0; i < n; i++) begin
         vac = m_lfsr[0];
         g   = m_lfsr[2:1];
         if (g > MAX_GAP) g = 2'(MAX_GAP);
         m_lfsr = lfsr_step(m_lfsr);
         viol = 1'b0;
         if (!vac) begin
            full++;
            if (ep != 0 && (full % ep) == 0) viol = 1'b1;
         end
         tx++;
         vc += int'(vac);
         er += int'(viol);
         cyc += 3 + int'(g);
         t.txn = tx; t.vac = vc; t.err = er;
         txn_q.push_back(t);
      end
      d.txn = tx; d.vac = vc; d.err = er; d.cycles = cyc;
      d.pass = full - er; d.fail = er; d.vatt = n - er;
      done_q.push_back(d);
   endtask

   // Monitor: implication tally plus scoreboard pops.
   initial begin
      int  prev_txn = 0, cyc = 0, pass = 0, fail = 0, vatt = 0;
      bit  prev_done = 0, h_a1 = 0, h_a2 = 0, h_b1 = 0;
      txn_exp_t  t;
      done_exp_t d;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_txn = 0; cyc = 0; pass = 0; fail = 0; vatt = 0;
            prev_done = 0; h_a1 = 0; h_a2 = 0; h_b1 = 0;
         end else begin
            if (h_a2 && h_b1) begin
               if (bus.a) pass++;
               else fail++;
            end
            if (h_a1 && !bus.b) vatt++;
            h_a2 = h_a1; h_a1 = bus.a; h_b1 = bus.b;
            if (bus.busy) cyc++;
            if (prev_done) check("done_one_cycle", int'(bus.done), 0);
            if (int'(bus.txn_cnt) == prev_txn + 1) begin
               if (txn_q.size() == 0) begin
                  check("txn_unexpected", int'(bus.txn_cnt), 0);
               end else begin
                  t = txn_q.pop_front();
                  check("txn_cnt", int'(bus.txn_cnt), t.txn);
                  check("vac_cnt", int'(bus.vac_cnt), t.vac);
                  check("err_cnt", int'(bus.err_cnt), t.err);
               end
            end
            if (bus.done) begin
               if (done_q.size() == 0) begin
                  check("done_unexpected", 1, 0);
               end else begin
                  d = done_q.pop_front();
                  check("done_txn", int'(bus.txn_cnt), d.txn);
                  check("done_vac", int'(bus.vac_cnt), d.vac);
                  check("done_err", int'(bus.err_cnt), d.err);
                  check("busy_cycles", cyc, d.cycles);
                  check("prop_pass", pass, d.pass);
                  check("prop_fail", fail, d.fail);
                  check("prop_vacuous", vatt, d.vatt);
                  check("busy_at_done", int'(bus.busy), 0);
                  check("leftover_txn", txn_q.size(), 0);
               end
               cyc = 0; pass = 0; fail = 0; vatt = 0;
            end
            prev_txn = int'(bus.txn_cnt);
            prev_done = bus.done;
         end
      end
   end

   task automatic pulse1(input int n, input int ep);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.num_txn = 8'(n); bus.err_period = 4'(ep);
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done1(input int limit);
      bit seen = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1;
            break;
         end
      end
      if (!seen) check("done_timeout", 0, 1);
   endtask

   task automatic burst1(input int n, input int ep);
      plan_burst(n, ep);
      pulse1(n, ep);
      wait_done1(n * 8 + 20);
   endtask

   // Directed run on the all-full instance.
   task automatic run_full(input int n, input int ep, input int exp_err);
      bit seen = 0;
      @(posedge clk); #1;
      bus2.start = 1'b1; bus2.num_txn = 8'(n); bus2.err_period = 4'(ep);
      @(posedge clk); #1;
      bus2.start = 1'b0;
      for (int i = 0; i < n * 8 + 20; i++) begin
         @(negedge clk);
         if (bus2.done) begin
            seen = 1;
            break;
         end
      end
      check("full_done_seen", int'(seen), 1);
      check("full_txn", int'(bus2.txn_cnt), n);
      check("full_vac", int'(bus2.vac_cnt), 0);
      check("full_err", int'(bus2.err_cnt), exp_err);
   endtask

   initial begin
      int cnt;
      bit seen;
      bus.start = 1'b0; bus.num_txn = 8'd0; bus.err_period = 4'd0;
      bus2.start = 1'b0; bus2.num_txn = 8'd0; bus2.err_period = 4'd0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_a", int'(bus.a), 0);
      check("rst_b", int'(bus.b), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_txn", int'(bus.txn_cnt), 0);
      check("rst_vac", int'(bus.vac_cnt), 0);
      check("rst_err", int'(bus.err_cnt), 0);

      // Empty burst: done with busy never raised.
      burst1(0, 0);

      // Random bursts, including every-full-violates and long bursts.
      burst1(10, 1);
      for (int k = 0; k < 6; k++) begin
         burst1(int'($urandom_range(1, 30)), int'($urandom_range(0, 15)));
      end
      burst1(200, 5);

      // start while busy is ignored; start in the DONE cycle is ignored.
      plan_burst(8, 2);
      pulse1(8, 2);
      repeat (5) @(posedge clk);
      #1 bus.start = 1'b1; bus.num_txn = 8'd3; bus.err_period = 4'd1;
      @(posedge clk); #1 bus.start = 1'b0;
      wait_done1(100);
      bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.busy) cnt++;
      end
      check("busy_after_done_start", cnt, 0);
      burst1(5, 3);

      // Asynchronous reset in a B phase with b high.
      plan_burst(20, 0);
      pulse1(20, 0);
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (bus.b) begin
            seen = 1;
            break;
         end
      end
      check("saw_b_high", int'(seen), 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_a", int'(bus.a), 0);
      check("arst_b", int'(bus.b), 0);
      check("arst_busy", int'(bus.busy), 0);
      check("arst_txn", int'(bus.txn_cnt), 0);
      txn_q.delete();
      done_q.delete();
      m_lfsr = SEED;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.done || bus.busy) cnt++;
      end
      check("quiet_after_reset", cnt, 0);
      // LFSR must restart from SEED.
      burst1(12, 2);

      // All-full instance, back-to-back transactions.
      run_full(4, 0, 0);
      run_full(6, 3, 2);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
